// File: rtl/ct_l2cache_data_ram_ctrl_pkg.sv
// Shared definitions for the L2 data RAM sequencer: state encoding, bank geometry
// and the per-bank read-data masking helper.
package ct_l2cache_data_ram_ctrl_pkg;

    localparam int L2C_DATA_INDEX_WIDTH = 14;
    localparam int BANK_NUM             = 4;
    localparam int BANK_W               = 128;
    localparam int LINE_W               = BANK_NUM * BANK_W;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        ACC   = 3'd2,
        WAIT  = 3'd3,
        RESP  = 3'd4
    } state_t;

    // Zero every 128-bit bank slice whose enable bit is clear.
    function automatic logic [LINE_W-1:0] bank_mask_data(
        input logic [LINE_W-1:0]   data,
        input logic [BANK_NUM-1:0] bank_en
    );
        logic [LINE_W-1:0] masked;
        masked = '0;
        for (int b = 0; b < BANK_NUM; b++) begin
            if (bank_en[b]) begin
                masked[b*BANK_W +: BANK_W] = data[b*BANK_W +: BANK_W];
            end
        end
        return masked;
    endfunction

endpackage

// File: rtl/ct_l2cache_data_resp_buf.sv
// Response capture register: latches masked bank read data on the last access
// cycle and holds it with resp_vld until the consumer accepts it.
module ct_l2cache_data_resp_buf
    import ct_l2cache_data_ram_ctrl_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cap_en,
    input  logic                cap_write,
    input  logic [BANK_NUM-1:0] cap_bank_en,
    input  logic [LINE_W-1:0]   cap_dout,
    input  logic                resp_rdy,
    output logic                resp_vld,
    output logic                resp_write,
    output logic [LINE_W-1:0]   resp_data,
    output logic                resp_done
);

    logic              vld_q, vld_d;
    logic              write_q, write_d;
    logic [LINE_W-1:0] data_q, data_d;

    always_comb begin
        vld_d   = vld_q;
        write_d = write_q;
        data_d  = data_q;
        if (cap_en) begin
            vld_d   = 1'b1;
            write_d = cap_write;
            data_d  = cap_write ? '0 : bank_mask_data(cap_dout, cap_bank_en);
        end else if (vld_q && resp_rdy) begin
            vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q   <= 1'b0;
            write_q <= 1'b0;
            data_q  <= '0;
        end else begin
            vld_q   <= vld_d;
            write_q <= write_d;
            data_q  <= data_d;
        end
    end

    assign resp_vld   = vld_q;
    assign resp_write = write_q;
    assign resp_data  = data_q;
    assign resp_done  = vld_q & resp_rdy;

endmodule

// File: rtl/ct_l2cache_data_ram_ctrl.sv
// Single-outstanding sequencer for the four L2 data banks: setup hold, one-cycle
// chip-enable pulse, programmable access latency, then a valid/ready response.
module ct_l2cache_data_ram_ctrl
    import ct_l2cache_data_ram_ctrl_pkg::*;
#(
    parameter int DATA_INDEX_LENTH = L2C_DATA_INDEX_WIDTH,
    parameter int LAT_W            = 3
) (
    input  logic                        forever_cpuclk,
    input  logic                        cpurst_b,
    input  logic [1:0]                  cfg_setup,
    input  logic [LAT_W-1:0]            cfg_latency,
    input  logic                        req_vld,
    output logic                        req_rdy,
    input  logic                        req_write,
    input  logic [DATA_INDEX_LENTH-1:0] req_idx,
    input  logic [3:0]                  req_bank_en,
    input  logic [511:0]                req_din,
    output logic [3:0]                  l2c_data_ram_cen,
    output logic [3:0]                  l2c_data_wen,
    output logic [DATA_INDEX_LENTH-1:0] l2c_data_index0,
    output logic [DATA_INDEX_LENTH-1:0] l2c_data_index1,
    output logic [DATA_INDEX_LENTH-1:0] l2c_data_index2,
    output logic [DATA_INDEX_LENTH-1:0] l2c_data_index3,
    output logic [511:0]                l2c_data_din,
    input  logic [511:0]                l2c_data_dout,
    output logic                        resp_vld,
    input  logic                        resp_rdy,
    output logic                        resp_write,
    output logic [511:0]                resp_data,
    output logic                        busy
);

    // Counter must hold both the 2-bit setup count and the latency count.
    localparam int CNT_W = (LAT_W > 2) ? LAT_W : 2;

    state_t                      state_q, state_d;
    logic [CNT_W-1:0]            cnt_q, cnt_d;
    logic                        write_q, write_d;
    logic [DATA_INDEX_LENTH-1:0] idx_q, idx_d;
    logic [BANK_NUM-1:0]         bank_en_q, bank_en_d;
    logic [LINE_W-1:0]           din_q, din_d;
    logic [LAT_W-1:0]            lat_q, lat_d;
    logic [BANK_NUM-1:0]         cen_q, cen_d;
    logic [BANK_NUM-1:0]         wen_q, wen_d;
    logic                        cap_en;
    logic                        resp_done;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        write_d   = write_q;
        idx_d     = idx_q;
        bank_en_d = bank_en_q;
        din_d     = din_q;
        lat_d     = lat_q;
        cen_d     = 4'hF;
        wen_d     = 4'hF;
        cap_en    = 1'b0;

        case (state_q)
            IDLE: begin
                if (req_vld) begin
                    write_d   = req_write;
                    idx_d     = req_idx;
                    bank_en_d = req_bank_en;
                    din_d     = req_din;
                    lat_d     = (cfg_latency == '0) ? LAT_W'(1) : cfg_latency;
                    if (cfg_setup != 2'd0) begin
                        state_d = SETUP;
                        cnt_d   = CNT_W'(cfg_setup);
                    end else begin
                        state_d = ACC;
                    end
                end
            end
            SETUP: begin
                if (cnt_q <= CNT_W'(1)) begin
                    state_d = ACC;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ACC: begin
                state_d = WAIT;
                cnt_d   = CNT_W'(lat_q);
            end
            WAIT: begin
                if (cnt_q <= CNT_W'(1)) begin
                    state_d = RESP;
                    cap_en  = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RESP: begin
                if (resp_done) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Strobes are registered, so they are decoded from the state being entered.
        if (state_d == ACC) begin
            cen_d = ~bank_en_d;
            wen_d = ~(bank_en_d & {BANK_NUM{write_d}});
        end
    end

    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            write_q   <= 1'b0;
            idx_q     <= '0;
            bank_en_q <= '0;
            din_q     <= '0;
            lat_q     <= LAT_W'(1);
            cen_q     <= 4'hF;
            wen_q     <= 4'hF;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            write_q   <= write_d;
            idx_q     <= idx_d;
            bank_en_q <= bank_en_d;
            din_q     <= din_d;
            lat_q     <= lat_d;
            cen_q     <= cen_d;
            wen_q     <= wen_d;
        end
    end

    ct_l2cache_data_resp_buf u_resp_buf (
        .clk         (forever_cpuclk),
        .rst_n       (cpurst_b),
        .cap_en      (cap_en),
        .cap_write   (write_q),
        .cap_bank_en (bank_en_q),
        .cap_dout    (l2c_data_dout),
        .resp_rdy    (resp_rdy),
        .resp_vld    (resp_vld),
        .resp_write  (resp_write),
        .resp_data   (resp_data),
        .resp_done   (resp_done)
    );

    assign req_rdy          = (state_q == IDLE);
    assign busy             = (state_q != IDLE);
    assign l2c_data_ram_cen = cen_q;
    assign l2c_data_wen     = wen_q;
    assign l2c_data_index0  = idx_q;
    assign l2c_data_index1  = idx_q;
    assign l2c_data_index2  = idx_q;
    assign l2c_data_index3  = idx_q;
    assign l2c_data_din     = din_q;

endmodule

// File: tb/tb_ct_l2cache_data_ram_ctrl.sv
// Directed bench for the L2 data RAM sequencer with a response scoreboard.
module tb_ct_l2cache_data_ram_ctrl;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [1:0]   cfg_setup;
    logic [2:0]   cfg_latency;
    logic         req_vld, req_rdy, req_write;
    logic [13:0]  req_idx;
    logic [3:0]   req_bank_en;
    logic [511:0] req_din;
    logic [3:0]   cen, wen;
    logic [13:0]  idx0, idx1, idx2, idx3;
    logic [511:0] ram_din, ram_dout;
    logic         resp_vld, resp_rdy, resp_write, busy;
    logic [511:0] resp_data;

    always #5 clk = ~clk;

    ct_l2cache_data_ram_ctrl #(.DATA_INDEX_LENTH(14), .LAT_W(3)) dut (
        .forever_cpuclk   (clk),
        .cpurst_b         (rst_n),
        .cfg_setup        (cfg_setup),
        .cfg_latency      (cfg_latency),
        .req_vld          (req_vld),
        .req_rdy          (req_rdy),
        .req_write        (req_write),
        .req_idx          (req_idx),
        .req_bank_en      (req_bank_en),
        .req_din          (req_din),
        .l2c_data_ram_cen (cen),
        .l2c_data_wen     (wen),
        .l2c_data_index0  (idx0),
        .l2c_data_index1  (idx1),
        .l2c_data_index2  (idx2),
        .l2c_data_index3  (idx3),
        .l2c_data_din     (ram_din),
        .l2c_data_dout    (ram_dout),
        .resp_vld         (resp_vld),
        .resp_rdy         (resp_rdy),
        .resp_write       (resp_write),
        .resp_data        (resp_data),
        .busy             (busy)
    );

    typedef struct {
        logic         write;
        logic [511:0] data;
        int           due;
    } exp_t;

    exp_t         sbq[$];
    int           total = 0;
    int           bad   = 0;
    int           cyc   = 0;
    int           exp_cen_cyc = 0;
    int           pulses = 0, wen_viol = 0, long_cen = 0, drive_err = 0;
    int           cen_cyc = 0;
    logic         prev_low = 1'b0;
    logic [3:0]   last_cen = 4'hF, last_wen = 4'hF;
    logic [13:0]  last_idx = '0;
    logic [13:0]  cur_idx = '0;
    logic [511:0] cur_din = '0;

    always @(posedge clk) cyc <= cyc + 1;

    // Bus monitor: records strobe pulses and checks drive stability while busy.
    always @(negedge clk) begin
        if (cen != 4'hF) begin
            pulses   <= pulses + 1;
            last_cen <= cen;
            last_wen <= wen;
            last_idx <= idx0;
            cen_cyc  <= cyc;
            if (prev_low) long_cen <= long_cen + 1;
        end
        if ((~wen & cen) != 4'h0) wen_viol <= wen_viol + 1;
        prev_low <= (cen != 4'hF);
        if (busy && (idx0 !== cur_idx || idx1 !== cur_idx || idx2 !== cur_idx ||
                     idx3 !== cur_idx || ram_din !== cur_din))
            drive_err <= drive_err + 1;
    end

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic start_req(input logic w, input logic [13:0] idx, input logic [3:0] ben,
                             input logic [511:0] din, input logic [1:0] setup, input logic [2:0] lat);
        req_write   = w;
        req_idx     = idx;
        req_bank_en = ben;
        req_din     = din;
        cfg_setup   = setup;
        cfg_latency = lat;
        req_vld     = 1'b1;
    endtask

    task automatic accept_req();
        exp_t e;
        int   k;
        int   lat_eff;
        @(posedge clk);
        #1;
        k       = cyc;
        req_vld = 1'b0;
        cur_idx = req_idx;
        cur_din = req_din;
        lat_eff = (cfg_latency == 3'd0) ? 1 : int'(cfg_latency);
        e.write = req_write;
        e.data  = '0;
        for (int b = 0; b < 4; b++)
            if (!req_write && req_bank_en[b]) e.data[b*128 +: 128] = ram_dout[b*128 +: 128];
        e.due       = k + int'(cfg_setup) + lat_eff + 1;
        exp_cen_cyc = k + int'(cfg_setup);
        sbq.push_back(e);
    endtask

    task automatic do_req(input logic w, input logic [13:0] idx, input logic [3:0] ben,
                          input logic [511:0] din, input logic [1:0] setup, input logic [2:0] lat);
        chk("req_rdy_idle", 512'(req_rdy), 512'(1));
        start_req(w, idx, ben, din, setup, lat);
        accept_req();
    endtask

    task automatic wait_resp(input string tag);
        exp_t e;
        int   n = 0;
        while (!resp_vld && n < 60) begin
            step(1);
            n++;
        end
        chk({tag, "_vld"}, 512'(resp_vld), 512'(1));
        if (sbq.size() > 0) begin
            e = sbq.pop_front();
            chk({tag, "_cyc"}, 512'(cyc), 512'(e.due));
            chk({tag, "_data"}, resp_data, e.data);
            chk({tag, "_write"}, 512'(resp_write), 512'(e.write));
        end else begin
            chk({tag, "_sb_empty"}, 512'(sbq.size()), 512'(1));
        end
        if (resp_rdy) step(1);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout cyc=%0d expected=finish", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        logic [511:0] d;
        logic [511:0] snap;
        int           p0, rdy_err, stab_err, vld_seen;

        rst_n = 1'b0; req_vld = 1'b0; req_write = 1'b0; req_idx = '0; req_bank_en = '0;
        req_din = '0; cfg_setup = '0; cfg_latency = '0; ram_dout = '0; resp_rdy = 1'b1;
        step(3);
        chk("rst_cen", 512'(cen), 512'(4'hF));
        chk("rst_wen", 512'(wen), 512'(4'hF));
        chk("rst_idx", 512'({idx0, idx1, idx2, idx3}), 512'(0));
        chk("rst_din", ram_din, '0);
        chk("rst_resp", 512'({resp_vld, resp_write, busy}), 512'(0));
        chk("rst_data", resp_data, '0);
        chk("rst_rdy", 512'(req_rdy), 512'(1));
        rst_n = 1'b1;
        step(2);

        // Basic full-line read
        ram_dout = {64{8'hA5}};
        p0 = pulses;
        do_req(1'b0, 14'h123, 4'hF, '0, 2'd0, 3'd1);
        wait_resp("rd_basic");
        chk("rd_basic_pulses", 512'(pulses - p0), 512'(1));
        chk("rd_basic_cen", 512'(last_cen), 512'(4'h0));
        chk("rd_basic_wen", 512'(last_wen), 512'(4'hF));
        chk("rd_basic_idx", 512'(last_idx), 512'(14'h123));
        chk("rd_basic_cencyc", 512'(cen_cyc), 512'(exp_cen_cyc));

        // Partial-bank write with setup
        for (int i = 0; i < 64; i++) d[i*8 +: 8] = 8'(i);
        for (int i = 0; i < 16; i++) ram_dout[i*32 +: 32] = $urandom;
        p0 = pulses;
        do_req(1'b1, 14'h2A5, 4'b0101, d, 2'd2, 3'd3);
        wait_resp("wr_part");
        chk("wr_part_pulses", 512'(pulses - p0), 512'(1));
        chk("wr_part_cen", 512'(last_cen), 512'(4'b1010));
        chk("wr_part_wen", 512'(last_wen), 512'(4'b1010));
        chk("wr_part_cencyc", 512'(cen_cyc), 512'(exp_cen_cyc));
        chk("wr_part_din", ram_din, d);

        // Single bank read, latency 0 behaves as 1
        for (int i = 0; i < 16; i++) ram_dout[i*32 +: 32] = $urandom;
        p0 = pulses;
        do_req(1'b0, 14'h3FFF, 4'b0010, '0, 2'd0, 3'd0);
        wait_resp("rd_lat0");
        chk("rd_lat0_cen", 512'(last_cen), 512'(4'b1101));
        chk("rd_lat0_pulses", 512'(pulses - p0), 512'(1));

        // Response back-pressure with a pending request
        resp_rdy = 1'b0;
        do_req(1'b0, 14'h055, 4'hF, '0, 2'd1, 3'd2);
        wait_resp("bp1");
        snap = resp_data;
        p0 = pulses;
        rdy_err = 0;
        stab_err = 0;
        start_req(1'b0, 14'h0AA, 4'b1100, '0, 2'd0, 3'd1);
        for (int i = 0; i < 10; i++) begin
            step(1);
            if (req_rdy !== 1'b0) rdy_err++;
            if (resp_data !== snap || resp_vld !== 1'b1) stab_err++;
        end
        chk("bp_rdy_low", 512'(rdy_err), 512'(0));
        chk("bp_stable", 512'(stab_err), 512'(0));
        chk("bp_no_cen", 512'(pulses - p0), 512'(0));
        resp_rdy = 1'b1;
        step(1);
        chk("bp_rdy_back", 512'(req_rdy), 512'(1));
        chk("bp_vld_drop", 512'(resp_vld), 512'(0));
        accept_req();
        chk("bp_accepted", 512'(busy), 512'(1));
        wait_resp("bp2");

        // Reset pulsed during WAIT
        do_req(1'b0, 14'h1F0, 4'hF, '0, 2'd0, 3'd5);
        step(2);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_cenwen", 512'({cen, wen}), 512'(8'hFF));
        chk("mid_rst_ctl", 512'({busy, req_rdy, resp_vld}), 512'(3'b010));
        chk("mid_rst_idx", 512'(idx0), 512'(0));
        chk("mid_rst_data", resp_data, '0);
        void'(sbq.pop_back());
        p0 = pulses;
        step(2);
        #2;
        rst_n = 1'b1;
        vld_seen = 0;
        for (int i = 0; i < 10; i++) begin
            step(1);
            if (resp_vld !== 1'b0) vld_seen++;
        end
        chk("post_rst_no_vld", 512'(vld_seen), 512'(0));
        chk("post_rst_no_cen", 512'(pulses - p0), 512'(0));
        ram_dout = {16{32'h1357_9BDF}};
        do_req(1'b0, 14'h0F0, 4'b1001, '0, 2'd0, 3'd2);
        wait_resp("post_rst_rd");

        // Config change after accept is ignored
        do_req(1'b0, 14'h321, 4'hF, '0, 2'd1, 3'd1);
        cfg_latency = 3'd7;
        cfg_setup   = 2'd3;
        wait_resp("cfg_chg");

        step(2);
        chk("wen_implies_cen", 512'(wen_viol), 512'(0));
        chk("cen_single_cycle", 512'(long_cen), 512'(0));
        chk("drive_stable", 512'(drive_err), 512'(0));
        chk("sb_drained", 512'(sbq.size()), 512'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
